ccff_bitstream_loader: RTL

- Initiator side of the configuration-chain protocol. The fabric's ccff_head/ccff_tail chain is the passive responder.
- Accepts configuration bytes over a valid/ready stream and serialises them MSB-first onto ccff_head. It issues exactly CHAIN_LEN shift enables, which gate prog_clk into the fabric.
- Optionally reads back the old chain contents emerging on ccff_tail.
- Sits beside fpga_top in the tile wrapper, between the host/SPI byte source and the fabric.

---
 rtl/ccff_bitstream_loader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: serialises configuration bytes MSB-first into a ccff_head/ccff_tail chain
//
// Initiator for the fabric configuration chain. Accepts bytes over a valid/ready stream,
// shifts them out one bit per prog_clk on ccff_head, and raises ccff_shift_en on exactly
// CHAIN_LEN cycles per load. Every output comes straight from a flop.
//
// Optional build macro CCFF_READBACK_EN: the old chain contents that emerge on ccff_tail are
// packed into bytes on rb_data/rb_valid. A byte that is still waiting for its consumer
// stalls the shift that would complete the next byte. When the macro is undefined,
// rb_data/rb_valid are tied to 0 and ccff_tail is ignored.
//
// Ports:
//   prog_clk      configuration clock; all state changes on the rising edge
//   prog_rst_n    asynchronous active-low reset; abandons any load in progress
//   start         one-cycle pulse that begins a load; ignored unless idle
//   cfg_data      configuration byte; bit 7 is shifted first
//   cfg_valid     cfg_data is valid
//   cfg_ready     loader takes a byte this cycle
//   ccff_head     serial bit into the fabric chain
//   ccff_shift_en chain advances on a prog_clk edge only while this is 1
//   ccff_tail     serial bit out of the fabric chain
//   rb_data       readback byte; the first bit to emerge is in bit 7
//   rb_valid      rb_data is valid
//   rb_ready      readback consumer accepts the byte
//   busy          a load is in progress
//   done          one-cycle pulse when a load completes
//   bit_count     bits shifted so far in the current load
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic             prog_clk,
    input  logic             prog_rst_n,
    input  logic             start,
    input  logic [7:0]       cfg_data,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             ccff_head,
    output logic             ccff_shift_en,
    input  logic             ccff_tail,
    output logic [7:0]       rb_data,
    output logic             rb_valid,
    input  logic             rb_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_count
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_BYTE = 3'd1;
    localparam logic [2:0] SHIFT     = 3'd2;
    localparam logic [2:0] DRAIN     = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    logic [2:0]       state, state_nxt;
    logic [7:0]       sreg, sreg_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             head_nxt, shifting, last_bit, byte_end, stall;

    // A shift happens at the coming edge only in SHIFT with the enable already raised.
    assign shifting = state == SHIFT && ccff_shift_en;
    assign last_bit = bit_count == LAST;
    assign byte_end = bit_idx == 3'd7;

    always_comb begin
        state_nxt   = state;
        sreg_nxt    = sreg;
        bit_idx_nxt = bit_idx;
        count_nxt   = bit_count;
        head_nxt    = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_nxt = WAIT_BYTE;
                count_nxt = '0;
            end
            WAIT_BYTE: if (cfg_valid && cfg_ready) begin
                state_nxt   = SHIFT;
                sreg_nxt    = {cfg_data[6:0], 1'b0};
                head_nxt    = cfg_data[7];
                bit_idx_nxt = '0;
            end
            SHIFT: if (shifting) begin
                count_nxt   = bit_count + 1'b1;
                bit_idx_nxt = bit_idx + 1'b1;
                state_nxt   = last_bit ? DRAIN : byte_end ? WAIT_BYTE : SHIFT;
                head_nxt    = sreg[7];
                sreg_nxt    = {sreg[6:0], 1'b0};
            end else begin
                head_nxt = ccff_head;
            end
            // A byte handed over at this edge no longer holds up completion.
            DRAIN: if (!rb_valid || rb_ready) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state         <= IDLE;
            sreg          <= '0;
            bit_idx       <= '0;
            bit_count     <= '0;
            cfg_ready     <= 1'b0;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nxt;
            sreg          <= sreg_nxt;
            bit_idx       <= bit_idx_nxt;
            bit_count     <= count_nxt;
            cfg_ready     <= state_nxt == WAIT_BYTE;
            ccff_head     <= head_nxt;
            ccff_shift_en <= state_nxt == SHIFT && !stall;
            busy          <= state_nxt != IDLE;
            done          <= state_nxt == DONE;
        end
    end

`ifdef CCFF_READBACK_EN
    logic [7:0] rb_sreg, rb_word;
    logic       rb_load, rb_valid_nxt;

    assign rb_word      = {rb_sreg[6:0], ccff_tail};
    assign rb_load      = shifting && (byte_end || last_bit);
    assign rb_valid_nxt = rb_load || (rb_valid && !rb_ready);
    // Hold off the shift that would complete a byte while the previous one is still unread.
    assign stall        = rb_valid_nxt && (bit_idx_nxt == 3'd7 || count_nxt == LAST);

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            rb_sreg  <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= rb_valid_nxt;
            if (rb_load) begin
                rb_sreg <= '0;
                // rb_sreg is cleared per byte, so a short final byte left-justifies with zero fill.
                rb_data <= rb_word << (3'd7 - bit_idx);
            end else if (shifting) begin
                rb_sreg <= rb_word;
            end
        end
    end
`else
    logic unused_rb;

    assign unused_rb = ccff_tail ^ rb_ready;
    assign stall     = 1'b0;
    assign rb_data   = '0;
    assign rb_valid  = 1'b0;
`endif
endmodule
